demux_dispatch_ctrl: RTL and testbench

Controller that sequences the 1-to-4 demultiplexer datapath. Accepts a stream of data words over a valid/ready handshake, chooses a destination channel (round-robin or explicitly addressed), and drives the demux select lines S1/S0 together with a one-hot per-channel valid. A single registered holding slot decouples the upstream and downstream handshakes. A free-running dispatch counter supports observability.

---
 rtl/demux_dispatch_ctrl.sv | 99 +++++++++
 tb/tb_demux_dispatch_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: single-slot valid/ready dispatcher driving 1-to-4 demux selects.
// Revision 1.0 - initial release.
`default_nettype none

module demux_dispatch_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MODE,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       DEST,
   output logic [WIDTH-1:0] D,
   output logic             S1,
   output logic             S0,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [15:0]      dispatch_cnt
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [3:0]       valid_q, valid_d;
   logic [15:0]      cnt_q, cnt_d;

   logic             full;
   logic             xfer_out;
   logic             xfer_in;
   logic [1:0]       dest;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         data_q  <= '0;
         valid_q <= 4'd0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      valid_d  = 4'd0;

      full     = (state_q == ST_FULL);
      xfer_out = full & out_ready[sel_q];
      // Refill in the same cycle the held word departs keeps one word per cycle.
      in_ready = ~rst & (~full | xfer_out);
      xfer_in  = in_valid & in_ready;
      dest     = MODE ? DEST : ptr_q;

      case (state_q)
         ST_EMPTY: if (xfer_in)              state_d = ST_FULL;
         ST_FULL:  if (xfer_out && !xfer_in) state_d = ST_EMPTY;
         default:                            state_d = ST_EMPTY;
      endcase

      if (xfer_in) begin
         data_d = in_data;
         sel_d  = dest;
         if (!MODE) ptr_d = ptr_q + 2'd1;
      end

      if (xfer_out) cnt_d = cnt_q + 16'd1;

      // out_valid is registered, so it is derived from the next-state slot contents.
      if (state_d == ST_FULL) valid_d[sel_d] = 1'b1;
   end

   assign D            = data_q;
   assign S1           = sel_q[1];
   assign S0           = sel_q[0];
   assign out_valid    = valid_q;
   assign dispatch_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: directed and randomized checks of demux_dispatch_ctrl against a slot model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_demux_dispatch_ctrl;

   logic        clk;
   logic        rst;
   logic        MODE;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  DEST;
   logic [7:0]  D;
   logic        S1;
   logic        S0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] dispatch_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   demux_dispatch_ctrl #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .MODE         (MODE),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .DEST         (DEST),
      .D            (D),
      .S1           (S1),
      .S0           (S0),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .dispatch_cnt (dispatch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one holding slot, a round-robin pointer and a transfer counter.
   bit          m_full;
   logic [7:0]  m_data;
   logic [1:0]  m_sel;
   logic [1:0]  m_ptr;
   logic [15:0] m_cnt;
   bit          m_acc;
   bit          m_out;
   bit          m_in;

   always @(posedge clk) begin
      if (rst) begin
         m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_acc = 0;
      end else begin
         m_out = m_full && out_ready[m_sel];
         m_in  = in_valid && (!m_full || m_out);
         m_acc = m_in;
         if (m_out) m_cnt = m_cnt + 16'd1;
         if (m_in) begin
            m_data = in_data;
            if (MODE) m_sel = DEST;
            else begin
               m_sel = m_ptr;
               m_ptr = m_ptr + 2'd1;
            end
            m_full = 1;
         end else if (m_out) begin
            m_full = 0;
         end
      end
   end

   function automatic logic [3:0] exp_ov();
      logic [3:0] v;
      v = 4'd0;
      if (m_full) v[m_sel] = 1'b1;
      return v;
   endfunction

   function automatic logic exp_ready();
      return !rst && (!m_full || out_ready[m_sel]);
   endfunction

   task automatic do_reset();
      rst = 1; in_valid = 0; in_data = 0; DEST = 0; MODE = 0; out_ready = 4'hF;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      MODE = 0; out_ready = 4'h0; in_valid = 1; in_data = 8'h55;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 4'b0001 || D !== 8'h55) begin
         n_fail++; $display("FAIL reset_pre_hold: ov=%b D=%h, want ov=0001 D=55", out_valid, D);
      end
      rst = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready_low: in_ready=%b, want 0", in_ready);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready_low2: in_ready=%b, want 0", in_ready);
      end
      rst = 0; in_valid = 0; out_ready = 4'hF;
      #1;
      n_checks++;
      if ({D, S1, S0, out_valid, dispatch_cnt, in_ready} !== {8'h00, 2'b00, 4'b0000, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: D=%h S=%b%b ov=%b cnt=%h rdy=%b, want D=00 S=00 ov=0000 cnt=0000 rdy=1",
                  D, S1, S0, out_valid, dispatch_cnt, in_ready);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] words [5];
      logic [3:0] ovs   [5];
      logic [1:0] sels  [5];
      words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      ovs   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      sels  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      MODE = 0; out_ready = 4'hF; in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         in_data = words[i];
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rr_ready[%0d]: in_ready=%b, want 1", i, in_ready);
         end
         @(negedge clk);
         n_checks++;
         if ({out_valid, S1, S0, D} !== {ovs[i], sels[i], words[i]}) begin
            n_fail++;
            $display("FAIL rr_word[%0d]: ov=%b S=%b%b D=%h, want ov=%b S=%b D=%h",
                     i, out_valid, S1, S0, D, ovs[i], sels[i], words[i]);
         end
      end
      in_valid = 0;
      @(negedge clk);
      n_checks++;
      if (dispatch_cnt !== 16'd5 || out_valid !== 4'b0000) begin
         n_fail++; $display("FAIL rr_count: cnt=%0d ov=%b, want cnt=5 ov=0000", dispatch_cnt, out_valid);
      end
   endtask

   task automatic test_directed();
      do_reset();
      MODE = 0; out_ready = 4'hF; in_valid = 1; in_data = 8'h01;
      @(negedge clk);
      MODE = 1; DEST = 2'b10; in_data = 8'h3C;
      @(negedge clk);
      n_checks++;
      if ({S1, S0, out_valid, D} !== {2'b10, 4'b0100, 8'h3C}) begin
         n_fail++; $display("FAIL dir_3c: S=%b%b ov=%b D=%h, want S=10 ov=0100 D=3c", S1, S0, out_valid, D);
      end
      DEST = 2'b01; in_data = 8'h5A;
      @(negedge clk);
      n_checks++;
      if ({S1, S0, out_valid, D} !== {2'b01, 4'b0010, 8'h5A}) begin
         n_fail++; $display("FAIL dir_5a: S=%b%b ov=%b D=%h, want S=01 ov=0010 D=5a", S1, S0, out_valid, D);
      end
      MODE = 0; DEST = 2'b11; in_data = 8'h77;
      @(negedge clk);
      n_checks++;
      if ({S1, S0, out_valid, D} !== {2'b01, 4'b0010, 8'h77}) begin
         n_fail++; $display("FAIL dir_ptr_kept: S=%b%b ov=%b D=%h, want S=01 ov=0010 D=77", S1, S0, out_valid, D);
      end
      in_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      MODE = 0; out_ready = 4'b1110; in_valid = 1; in_data = 8'h11;
      @(negedge clk);
      n_checks++;
      if ({D, S1, S0, out_valid} !== {8'h11, 2'b00, 4'b0001}) begin
         n_fail++; $display("FAIL bp_load: D=%h S=%b%b ov=%b, want D=11 S=00 ov=0001", D, S1, S0, out_valid);
      end
      in_data = 8'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall_ready[%0d]: in_ready=%b, want 0", i, in_ready);
         end
         @(negedge clk);
         n_checks++;
         if ({D, out_valid, dispatch_cnt} !== {8'h11, 4'b0001, 16'd0}) begin
            n_fail++; $display("FAIL bp_held[%0d]: D=%h ov=%b cnt=%0d, want D=11 ov=0001 cnt=0", i, D, out_valid, dispatch_cnt);
         end
      end
      out_ready = 4'hF;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({D, S1, S0, out_valid, dispatch_cnt} !== {8'h22, 2'b01, 4'b0010, 16'd1}) begin
         n_fail++;
         $display("FAIL bp_refill: D=%h S=%b%b ov=%b cnt=%0d, want D=22 S=01 ov=0010 cnt=1", D, S1, S0, out_valid, dispatch_cnt);
      end
      in_valid = 0;
   endtask

   task automatic test_mode_switch();
      @(negedge clk);
      out_ready = 4'b1011; MODE = 0; in_valid = 1; in_data = 8'h33;
      @(negedge clk);
      n_checks++;
      if ({D, S1, S0, out_valid} !== {8'h33, 2'b10, 4'b0100}) begin
         n_fail++; $display("FAIL ms_load: D=%h S=%b%b ov=%b, want D=33 S=10 ov=0100", D, S1, S0, out_valid);
      end
      MODE = 1; DEST = 2'b00; in_data = 8'h44;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL ms_stall_ready[%0d]: in_ready=%b, want 0", i, in_ready);
         end
         @(negedge clk);
         n_checks++;
         if ({D, S1, S0, out_valid} !== {8'h33, 2'b10, 4'b0100}) begin
            n_fail++; $display("FAIL ms_held[%0d]: D=%h S=%b%b ov=%b, want D=33 S=10 ov=0100", i, D, S1, S0, out_valid);
         end
      end
      out_ready = 4'hF;
      @(negedge clk);
      n_checks++;
      if ({D, S1, S0, out_valid} !== {8'h44, 2'b00, 4'b0001}) begin
         n_fail++; $display("FAIL ms_next: D=%h S=%b%b ov=%b, want D=44 S=00 ov=0001", D, S1, S0, out_valid);
      end
      in_valid = 0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 4'b0000 || dispatch_cnt !== 16'd4) begin
         n_fail++; $display("FAIL ms_drain: ov=%b cnt=%0d, want ov=0000 cnt=4", out_valid, dispatch_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n_checks++;
         if ({D, S1, S0, out_valid, dispatch_cnt} !== {m_data, m_sel, exp_ov(), m_cnt}) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: D=%h S=%b%b ov=%b cnt=%h, want D=%h S=%b ov=%b cnt=%h",
                     i, D, S1, S0, out_valid, dispatch_cnt, m_data, m_sel, exp_ov(), m_cnt);
         end
         rst = ($urandom_range(0, 59) == 0);
         if (!in_valid || m_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            DEST     = 2'($urandom);
         end
         MODE      = 1'($urandom);
         out_ready = 4'($urandom);
         #1;
         n_checks++;
         if (in_ready !== exp_ready()) begin
            n_fail++; $display("FAIL rand_ready[%0d]: in_ready=%b, want %b", i, in_ready, exp_ready());
         end
      end
      rst = 0; in_valid = 0;
   endtask

   task automatic test_counter_wrap();
      logic [15:0] exp_cnt [3];
      exp_cnt = '{16'hFFFF, 16'h0000, 16'h0001};
      do_reset();
      MODE = 0; out_ready = 4'hF; in_valid = 1; in_data = 8'hC3;
      repeat (65535) @(negedge clk);
      n_checks++;
      if (dispatch_cnt !== 16'hFFFE || m_cnt !== 16'hFFFE) begin
         n_fail++; $display("FAIL wrap_pre: cnt=%h model=%h, want fffe", dispatch_cnt, m_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (dispatch_cnt !== exp_cnt[i]) begin
            n_fail++; $display("FAIL wrap[%0d]: cnt=%h, want %h", i, dispatch_cnt, exp_cnt[i]);
         end
      end
      in_valid = 0;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_round_robin();
      test_directed();
      test_backpressure();
      test_mode_switch();
      test_random();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
